spi_frame_master: RTL and testbench

Serializing SPI master that drives the raybox-zero vector and register SPI slave ports (`i_vec_*` / `i_reg_*`) from a parallel command interface. It is used by test harnesses, firmware-side LA bridges and demo sequencers to write view vectors and general registers without bit-banging. Each accepted request becomes exactly one SPI mode-0 frame: a 4-bit command followed by a variable-length payload, MSB first.

---
 rtl/spi_frame_master.sv | 199 +++++++++++++++++++
 tb/tb_spi_frame_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_master.sv
// spi_frame_master: turns one parallel request into one SPI mode-0 frame
// (4-bit command, then 0..24 payload bits, MSB first).
// DIV sets the SCLK half-period in clk cycles (1..255).
// Optional build macro SPI_FRAME_MASTER_SKID_EN adds a one-entry request
// buffer, so the next frame can start straight out of GUARD.
module spi_frame_master #(
  parameter int DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [3:0]  i_cmd,
  input  logic [23:0] i_data,
  input  logic [4:0]  i_len,
  output logic        o_csb,
  output logic        o_sclk,
  output logic        o_mosi,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_HIGH,
    ST_LOW,
    ST_TAIL,
    ST_GUARD
  } state_t;

  localparam logic [7:0] HP_LAST = 8'(DIV - 1);

  state_t      state_reg;
  logic [7:0]  hp_cnt_reg;
  logic [4:0]  bit_cnt_reg;
  logic [4:0]  frame_bits_reg;
  logic [27:0] shift_reg;
  logic        csb_reg;
  logic        sclk_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        ready_reg;

  logic [4:0]  in_len;
  logic [27:0] in_word;
  logic [4:0]  in_bits;
  logic        accept;
  logic        hp_last;
  logic        guard_exit;
  logic        start;
  logic [27:0] start_word;
  logic [4:0]  start_bits;
  logic        ready_next;

  // Clamp the payload length and left-justify the request into a frame word
  always_comb begin
    in_len  = (i_len > 5'd24) ? 5'd24 : i_len;
    in_word = {i_cmd, i_data << (5'd24 - in_len)};
    in_bits = in_len + 5'd4;
  end

  assign accept     = i_valid & ready_reg;
  assign hp_last    = (hp_cnt_reg == HP_LAST);
  assign guard_exit = (state_reg == ST_GUARD) & hp_last;

`ifdef SPI_FRAME_MASTER_SKID_EN
  logic        buf_valid_reg;
  logic [27:0] buf_word_reg;
  logic [4:0]  buf_bits_reg;
  logic        buf_load;
  logic        buf_take;

  // A buffered frame always has priority at GUARD exit; a fresh request
  // goes straight to the sequencer only when nothing is waiting.
  assign buf_take   = guard_exit & buf_valid_reg;
  assign buf_load   = accept & (state_reg != ST_IDLE) & ~guard_exit;
  assign start      = buf_take | (accept & ((state_reg == ST_IDLE) | guard_exit));
  assign start_word = buf_take ? buf_word_reg : in_word;
  assign start_bits = buf_take ? buf_bits_reg : in_bits;
  assign ready_next = ~(buf_load | (buf_valid_reg & ~buf_take));

  // One-entry holding buffer for a request accepted while a frame is running
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_reg <= 1'b0;
      buf_word_reg  <= '0;
      buf_bits_reg  <= '0;
    end else if (buf_load) begin
      buf_valid_reg <= 1'b1;
      buf_word_reg  <= in_word;
      buf_bits_reg  <= in_bits;
    end else if (buf_take) begin
      buf_valid_reg <= 1'b0;
    end
  end
`else
  assign start      = accept & (state_reg == ST_IDLE);
  assign start_word = in_word;
  assign start_bits = in_bits;
  assign ready_next = ((state_reg == ST_IDLE) & ~accept) | guard_exit;
`endif

  // Frame sequencer: phase timing, bit counting and the registered SPI pins
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      hp_cnt_reg     <= '0;
      bit_cnt_reg    <= '0;
      frame_bits_reg <= '0;
      shift_reg      <= '0;
      csb_reg        <= 1'b1;
      sclk_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      ready_reg      <= 1'b1;
    end else begin
      done_reg  <= 1'b0;
      ready_reg <= ready_next;
      if (state_reg != ST_IDLE) begin
        hp_cnt_reg <= hp_last ? 8'd0 : hp_cnt_reg + 8'd1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg      <= ST_LEAD;
            bit_cnt_reg    <= 5'd1;
            frame_bits_reg <= start_bits;
            shift_reg      <= start_word;
            csb_reg        <= 1'b0;
            sclk_reg       <= 1'b0;
            busy_reg       <= 1'b1;
          end
        end
        ST_LEAD: begin
          if (hp_last) begin
            state_reg <= ST_HIGH;
            sclk_reg  <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (hp_last) begin
            sclk_reg <= 1'b0;
            if (bit_cnt_reg == frame_bits_reg) begin
              state_reg <= ST_TAIL;
            end else begin
              state_reg   <= ST_LOW;
              shift_reg   <= {shift_reg[26:0], 1'b0};
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end
        end
        ST_LOW: begin
          if (hp_last) begin
            state_reg <= ST_HIGH;
            sclk_reg  <= 1'b1;
          end
        end
        ST_TAIL: begin
          if (hp_last) begin
            state_reg <= ST_GUARD;
            csb_reg   <= 1'b1;
            shift_reg <= '0;
          end
        end
        ST_GUARD: begin
          if (hp_last) begin
            done_reg <= 1'b1;
            if (start) begin
              state_reg      <= ST_LEAD;
              bit_cnt_reg    <= 5'd1;
              frame_bits_reg <= start_bits;
              shift_reg      <= start_word;
              csb_reg        <= 1'b0;
            end else begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          csb_reg   <= 1'b1;
          sclk_reg  <= 1'b0;
          shift_reg <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = ready_reg;
  assign o_csb   = csb_reg;
  assign o_sclk  = sclk_reg;
  assign o_mosi  = shift_reg[27];
  assign o_busy  = busy_reg;
  assign o_done  = done_reg;

endmodule

// File: tb/tb_spi_frame_master.sv
// tb_spi_frame_master: scoreboard bench for spi_frame_master.
// Instance 0 runs with DIV=2, instance 1 with DIV=1. A monitor decodes every
// frame off the SPI pins and checks it against the queue of expected frames.
module tb_spi_frame_master;
  localparam int N_DUT        = 2;
  localparam int CYCLE_BUDGET = 2000;

`ifdef SPI_FRAME_MASTER_SKID_EN
  localparam int EXP_GAP      = 2;
  localparam bit EXP_READY_BUSY = 1'b1;
`else
  localparam int EXP_GAP      = 3;
  localparam bit EXP_READY_BUSY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        valid [N_DUT];
  logic        ready [N_DUT];
  logic [3:0]  cmd   [N_DUT];
  logic [23:0] data  [N_DUT];
  logic [4:0]  len   [N_DUT];
  logic        csb   [N_DUT];
  logic        sclk  [N_DUT];
  logic        mosi  [N_DUT];
  logic        busy  [N_DUT];
  logic        done  [N_DUT];

  for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
    spi_frame_master #(.DIV((gi == 0) ? 2 : 1)) u_dut (
      .clk    (clk),
      .reset  (reset),
      .i_valid(valid[gi]),
      .o_ready(ready[gi]),
      .i_cmd  (cmd[gi]),
      .i_data (data[gi]),
      .i_len  (len[gi]),
      .o_csb  (csb[gi]),
      .o_sclk (sclk[gi]),
      .o_mosi (mosi[gi]),
      .o_busy (busy[gi]),
      .o_done (done[gi])
    );
  end

  typedef struct {
    int          dut;
    logic [27:0] word;
    int          nbits;
    int          cycles;
    int          first_rise;
  } exp_t;

  exp_t exp_q[$];
  int   gap_q[$];
  int   n_compared = 0;
  int   n_mismatch = 0;

  logic [27:0] mon_word       [N_DUT];
  int          mon_rises      [N_DUT];
  int          mon_cyc        [N_DUT];
  int          mon_first_rise [N_DUT];
  int          mon_gap        [N_DUT];
  int          done_cnt       [N_DUT];
  bit          in_frame       [N_DUT];
  logic        prev_sclk      [N_DUT];
  logic        prev_csb       [N_DUT];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: command followed by the low min(len,24) payload bits
  function automatic exp_t model(input int dut, input logic [3:0] c,
                                 input logic [23:0] d, input logic [4:0] l);
    exp_t        e;
    int          lc;
    logic [27:0] one;
    logic [27:0] mask;
    lc   = (l > 5'd24) ? 24 : int'(l);
    one  = 28'd1;
    mask = (one << lc) - 28'd1;
    e.dut        = dut;
    e.word       = ({24'd0, c} << lc) | ({4'd0, d} & mask);
    e.nbits      = 4 + lc;
    e.cycles     = ((dut == 0) ? 2 : 1) * (2 * e.nbits + 2);
    e.first_rise = ((dut == 0) ? 2 : 1) + 1;
    return e;
  endfunction

  // Pin-level monitor: decodes frames and scores them when o_done pulses
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N_DUT; i++) begin
        if (reset === 1'b1) begin
          mon_word[i]  = '0;
          mon_rises[i] = 0;
          mon_cyc[i]   = 0;
          mon_gap[i]   = 0;
          in_frame[i]  = 1'b0;
        end else begin
          if (done[i] === 1'b1) begin
            done_cnt[i]++;
            check($sformatf("d%0d_done_expected", i), (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              $display("frame dut%0d word=0x%0h bits=%0d cycles=%0d first_rise=%0d",
                       i, mon_word[i], mon_rises[i], mon_cyc[i], mon_first_rise[i]);
              check($sformatf("d%0d_dut", i), i, e.dut);
              check($sformatf("d%0d_word", i), mon_word[i], e.word);
              check($sformatf("d%0d_bits", i), mon_rises[i], e.nbits);
              check($sformatf("d%0d_busy_cycles", i), mon_cyc[i], e.cycles);
              check($sformatf("d%0d_first_rise", i), mon_first_rise[i], e.first_rise);
            end
            in_frame[i] = 1'b0;
          end
          if (csb[i] === 1'b0 && prev_csb[i] === 1'b1) begin
            in_frame[i]  = 1'b1;
            mon_cyc[i]   = 0;
            mon_rises[i] = 0;
            mon_word[i]  = '0;
            if (i == 0) gap_q.push_back(mon_gap[i]);
            mon_gap[i]   = 0;
          end
          if (csb[i] === 1'b1) mon_gap[i]++;
          if (in_frame[i]) mon_cyc[i]++;
          if (sclk[i] === 1'b1 && prev_sclk[i] === 1'b0) begin
            mon_word[i] = {mon_word[i][26:0], mosi[i]};
            mon_rises[i]++;
            if (mon_rises[i] == 1) mon_first_rise[i] = mon_cyc[i];
          end
        end
        prev_sclk[i] = sclk[i];
        prev_csb[i]  = csb[i];
      end
    end
  end

  // Present a request and hold it until accepted; valid stays high on return
  task automatic send(input int i, input logic [3:0] c, input logic [23:0] d,
                      input logic [4:0] l);
    bit ok;
    ok = 1'b0;
    cmd[i]   = c;
    data[i]  = d;
    len[i]   = l;
    valid[i] = 1'b1;
    for (int n = 0; n < CYCLE_BUDGET && !ok; n++) begin
      if (ready[i] === 1'b1) begin
        exp_q.push_back(model(i, c, d, l));
        ok = 1'b1;
      end
      @(negedge clk);
      #1;
    end
    check($sformatf("d%0d_accept_in_time", i), ok, 1);
  endtask

  // Wait until the done counter reaches target, optionally scrambling inputs
  task automatic wait_done(input int i, input int target, input bit scramble);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < CYCLE_BUDGET && !ok; n++) begin
      if (scramble) begin
        data[i] = 24'($urandom);
        cmd[i]  = 4'($urandom);
        len[i]  = 5'($urandom);
      end
      @(negedge clk);
      #1;
      if (done_cnt[i] >= target) ok = 1'b1;
    end
    check($sformatf("d%0d_done_in_time", i), ok, 1);
  endtask

  task automatic check_idle_pins(input string tag, input int i);
    check({tag, "_csb"},   csb[i],   1);
    check({tag, "_sclk"},  sclk[i],  0);
    check({tag, "_mosi"},  mosi[i],  0);
    check({tag, "_busy"},  busy[i],  0);
    check({tag, "_done"},  done[i],  0);
    check({tag, "_ready"}, ready[i], 1);
  endtask

  initial begin
    int base;
    bit ok;
    reset = 1'b1;
    for (int i = 0; i < N_DUT; i++) begin
      valid[i]    = 1'b0;
      cmd[i]      = '0;
      data[i]     = '0;
      len[i]      = '0;
      done_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    check_idle_pins("reset_d0", 0);
    check_idle_pins("reset_d1", 1);
    reset = 1'b0;
    @(negedge clk);
    #1;

    // Single frame, DIV=2: 0011 101101
    base = done_cnt[0];
    send(0, 4'h3, 24'b101101, 5'd6);
    valid[0] = 1'b0;
    check("single_busy_after_accept", busy[0], 1);
    check("single_csb_after_accept", csb[0], 0);
    check("single_ready_while_busy", ready[0], EXP_READY_BUSY);
    wait_done(0, base + 1, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    check("single_done_count", done_cnt[0] - base, 1);
    check_idle_pins("single_after", 0);

    // Zero payload, DIV=1
    base = done_cnt[1];
    send(1, 4'hA, 24'hFFFFFF, 5'd0);
    valid[1] = 1'b0;
    wait_done(1, base + 1, 1'b0);

    // Length clamp: 31 -> 24
    base = done_cnt[0];
    send(0, 4'h5, 24'hC0FFEE, 5'd31);
    valid[0] = 1'b0;
    wait_done(0, base + 1, 1'b0);

    // Inputs change every cycle after accept
    base = done_cnt[0];
    send(0, 4'h9, 24'h123456, 5'd20);
    valid[0] = 1'b0;
    wait_done(0, base + 1, 1'b1);

    // A few random frames on the DIV=1 instance
    for (int k = 0; k < 4; k++) begin
      base = done_cnt[1];
      send(1, 4'($urandom), 24'($urandom), 5'($urandom_range(0, 31)));
      valid[1] = 1'b0;
      wait_done(1, base + 1, 1'b0);
    end

    // Reset at bit 7 of a 28-bit frame
    base = done_cnt[0];
    send(0, 4'hF, 24'hABCDEF, 5'd24);
    valid[0] = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < CYCLE_BUDGET && !ok; n++) begin
      if (mon_rises[0] >= 7) ok = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    check("midreset_reached_bit7", ok, 1);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    check_idle_pins("midreset", 0);
    reset = 1'b0;
    send(0, 4'h6, 24'h00005A, 5'd8);
    valid[0] = 1'b0;
    check("midreset_next_busy", busy[0], 1);
    check("midreset_next_csb", csb[0], 0);
    wait_done(0, base + 1, 1'b0);
    check("midreset_done_count", done_cnt[0] - base, 1);

    // Back-to-back: valid held across three requests
    repeat (3) @(negedge clk);
    #1;
    gap_q.delete();
    base = done_cnt[0];
    send(0, 4'h1, 24'h0000A5, 5'd8);
    send(0, 4'h2, 24'h00003C, 5'd8);
    send(0, 4'h4, 24'h0000FF, 5'd8);
    valid[0] = 1'b0;
    wait_done(0, base + 3, 1'b0);
    check("b2b_frame_count", gap_q.size(), 3);
    if (gap_q.size() == 3) begin
      check("b2b_gap_1_2", gap_q[1], EXP_GAP);
      check("b2b_gap_2_3", gap_q[2], EXP_GAP);
    end

    repeat (5) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    check_idle_pins("final_d0", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
